// File: rtl/line_encoder_if.sv
// Bundles the event lines, flush control and the code output stream of line_encoder.
// The master modport is the encoder itself; the slave modport is the environment around it.
interface line_encoder_if #(
    parameter int WIDTH = 4
);
    logic [2**WIDTH-1:0] line;
    logic                clear;
    logic                out_ready;
    logic                out_valid;
    logic [WIDTH-1:0]    code;
    logic [WIDTH:0]      pending_cnt;
    logic                overrun;

    modport master (
        input  line,
        input  clear,
        input  out_ready,
        output out_valid,
        output code,
        output pending_cnt,
        output overrun
    );

    modport slave (
        output line,
        output clear,
        output out_ready,
        input  out_valid,
        input  code,
        input  pending_cnt,
        input  overrun
    );
endinterface

// File: rtl/line_encoder.sv
// Collects event lines into a pending set and emits them one at a time as binary codes,
// picking round-robin from a rotating pointer and flagging events that land on a pending line.
module line_encoder #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    line_encoder_if.master bus
);
    localparam int N = 2**WIDTH;

    logic [N-1:0]     pending;
    logic [N-1:0]     pending_next;
    logic [N-1:0]     load_mask;
    logic [WIDTH-1:0] ptr;
    logic [WIDTH-1:0] sel;
    logic [WIDTH-1:0] idx;
    logic [WIDTH-1:0] code_r;
    logic [WIDTH:0]   cnt_r;
    logic [WIDTH:0]   cnt_next;
    logic             valid_r;
    logic             overrun_r;
    logic             found;
    logic             load;
    logic             take;
    logic             overrun_hit;

    // Stream handshake: a code transfers on any edge where out_valid && out_ready.
    // While out_valid=1 and out_ready=0, code and out_valid hold; a new code is
    // loaded whenever the output stage is empty or being drained this cycle.
    assign load = !valid_r || bus.out_ready;

    always_comb begin
        found = 1'b0;
        sel   = ptr;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = ptr + WIDTH'(k);
            if (!found && pending[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign take      = load && found;
    assign load_mask = take ? ({{(N-1){1'b0}}, 1'b1} << sel) : '0;

    // A line re-firing on the bit being loaded is a fresh event, not an overrun.
    assign overrun_hit  = |(bus.line & pending & ~load_mask);
    assign pending_next = (pending & ~load_mask) | bus.line;

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < N; i++) begin
            cnt_next = cnt_next + (WIDTH+1)'(pending_next[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            cnt_r     <= '0;
            ptr       <= '0;
            code_r    <= '0;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else if (bus.clear) begin
            pending   <= '0;
            cnt_r     <= '0;
            ptr       <= '0;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            pending <= pending_next;
            cnt_r   <= cnt_next;
            if (overrun_hit) begin
                overrun_r <= 1'b1;
            end
            if (load) begin
                if (found) begin
                    code_r  <= sel;
                    valid_r <= 1'b1;
                    ptr     <= sel + 1'b1;
                end else begin
                    valid_r <= 1'b0;
                end
            end
        end
    end

    assign bus.out_valid   = valid_r;
    assign bus.code        = code_r;
    assign bus.pending_cnt = cnt_r;
    assign bus.overrun     = overrun_r;
endmodule

// File: tb/tb_line_encoder.sv
// Directed and randomized checks of line_encoder against a set-based reference model.
module tb_line_encoder;
    localparam int WIDTH = 4;
    localparam int N     = 2**WIDTH;

    logic clk;
    logic rst_n;

    line_encoder_if #(.WIDTH(WIDTH)) bus ();

    line_encoder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model: pending events as a set, output stage as plain variables
    bit m_pend[N];
    int m_ptr;
    bit m_valid;
    int m_code;
    bit m_ovr;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] got_q[$];
    int               acc_log[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        m_ptr = 0; m_valid = 1'b0; m_code = 0; m_ovr = 1'b0;
    endtask

    task automatic model_edge(input logic [N-1:0] ln, input logic clr, input logic rdy);
        int s;
        if (clr) begin
            for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
            m_ptr = 0; m_valid = 1'b0; m_ovr = 1'b0;
            return;
        end
        s = -1;
        if (!m_valid || rdy) begin
            for (int k = 0; k < N; k++) begin
                if (s < 0 && m_pend[(m_ptr + k) % N]) s = (m_ptr + k) % N;
            end
            if (s >= 0) begin
                m_pend[s] = 1'b0;
                m_code    = s;
                m_valid   = 1'b1;
                m_ptr     = (s + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (ln[i]) begin
                if (m_pend[i]) m_ovr = 1'b1;
                m_pend[i] = 1'b1;
            end
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'(m_valid));
        check({tag, "_code"}, 32'(bus.code), m_code);
        check({tag, "_cnt"}, 32'(bus.pending_cnt), m_count());
        check({tag, "_overrun"}, 32'(bus.overrun), 32'(m_ovr));
    endtask

    // driver: one clock cycle with the given inputs, then model update and scoreboard
    task automatic step(input logic [N-1:0] ln, input logic clr, input logic rdy, input string tag);
        bus.line = ln; bus.clear = clr; bus.out_ready = rdy;
        if (bus.out_valid && rdy && !clr) begin
            got_q.push_back(bus.code);
            acc_log.push_back(int'(bus.code));
        end
        if (m_valid && rdy && !clr) exp_q.push_back(m_code[WIDTH-1:0]);
        @(posedge clk);
        model_edge(ln, clr, rdy);
        #1;
        compare_model(tag);
        check({tag, "_acc_n"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            check({tag, "_acc_code"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic expect_log(input string tag, input int n, input int e0, input int e1,
                              input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        check({tag, "_log_n"}, acc_log.size(), n);
        for (int i = 0; i < n && i < acc_log.size(); i++) check({tag, "_log"}, acc_log[i], e[i]);
        acc_log.delete();
    endtask

    initial begin
        logic [N-1:0] ln;
        rst_n = 1'b0;
        bus.line = '0; bus.clear = 1'b0; bus.out_ready = 1'b0;
        model_reset();
        #12;
        check("reset_valid", 32'(bus.out_valid), 0);
        check("reset_code", 32'(bus.code), 0);
        check("reset_cnt", 32'(bus.pending_cnt), 0);
        check("reset_overrun", 32'(bus.overrun), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single event: two edges of latency, one cycle of valid
        step(16'h0001, 1'b0, 1'b1, "t1a");
        check("t1_not_yet", 32'(bus.out_valid), 0);
        step(16'h0000, 1'b0, 1'b1, "t1b");
        check("t1_valid", 32'(bus.out_valid), 1);
        check("t1_code", 32'(bus.code), 0);
        step(16'h0000, 1'b0, 1'b1, "t1c");
        check("t1_one_cycle", 32'(bus.out_valid), 0);
        expect_log("t1", 1, 0, 0, 0, 0);

        // multi-hot burst from ptr=0
        step(16'h0000, 1'b1, 1'b1, "t2clr");
        step(16'h8421, 1'b0, 1'b1, "t2a");
        check("t2_cnt4", 32'(bus.pending_cnt), 4);
        step(16'h0000, 1'b0, 1'b1, "t2b");
        check("t2_code0", 32'(bus.code), 0);
        check("t2_cnt3", 32'(bus.pending_cnt), 3);
        step(16'h0000, 1'b0, 1'b1, "t2c");
        check("t2_code5", 32'(bus.code), 5);
        check("t2_cnt2", 32'(bus.pending_cnt), 2);
        step(16'h0000, 1'b0, 1'b1, "t2d");
        check("t2_code10", 32'(bus.code), 10);
        check("t2_cnt1", 32'(bus.pending_cnt), 1);
        step(16'h0000, 1'b0, 1'b1, "t2e");
        check("t2_code15", 32'(bus.code), 15);
        check("t2_cnt0", 32'(bus.pending_cnt), 0);
        step(16'h0000, 1'b0, 1'b1, "t2f");
        expect_log("t2", 4, 0, 5, 10, 15);

        // round-robin after serving code 5
        step(16'h0000, 1'b1, 1'b1, "t3clr");
        step(16'h0020, 1'b0, 1'b1, "t3a");
        step(16'h0204, 1'b0, 1'b1, "t3b");
        step(16'h0000, 1'b0, 1'b1, "t3c");
        check("t3_code9", 32'(bus.code), 9);
        step(16'h0000, 1'b0, 1'b1, "t3d");
        check("t3_code2", 32'(bus.code), 2);
        step(16'h0000, 1'b0, 1'b1, "t3e");
        expect_log("t3", 3, 5, 9, 2, 0);

        // wrap after serving code 15
        step(16'h0000, 1'b1, 1'b1, "t4clr");
        step(16'h8000, 1'b0, 1'b1, "t4a");
        step(16'h4001, 1'b0, 1'b1, "t4b");
        step(16'h0000, 1'b0, 1'b1, "t4c");
        check("t4_code0", 32'(bus.code), 0);
        step(16'h0000, 1'b0, 1'b1, "t4d");
        check("t4_code14", 32'(bus.code), 14);
        step(16'h0000, 1'b0, 1'b1, "t4e");
        expect_log("t4", 3, 15, 0, 14, 0);

        // backpressure and overrun, then clear
        step(16'h0000, 1'b1, 1'b1, "t5clr");
        step(16'h0008, 1'b0, 1'b1, "t5a");
        step(16'h0000, 1'b0, 1'b0, "t5b");
        step(16'h0080, 1'b0, 1'b0, "t5c");
        step(16'h0000, 1'b0, 1'b0, "t5d");
        check("t5_no_ovr_yet", 32'(bus.overrun), 0);
        step(16'h0080, 1'b0, 1'b0, "t5e");
        check("t5_hold_code", 32'(bus.code), 3);
        check("t5_hold_valid", 32'(bus.out_valid), 1);
        check("t5_overrun", 32'(bus.overrun), 1);
        step(16'h0000, 1'b0, 1'b1, "t5f");
        step(16'h0000, 1'b0, 1'b1, "t5g");
        step(16'h0000, 1'b0, 1'b1, "t5h");
        expect_log("t5", 2, 3, 7, 0, 0);
        step(16'h0000, 1'b1, 1'b1, "t5clr2");
        check("t5_clr_ovr", 32'(bus.overrun), 0);
        check("t5_clr_valid", 32'(bus.out_valid), 0);
        check("t5_clr_cnt", 32'(bus.pending_cnt), 0);

        // asynchronous reset mid-stream with three events pending
        step(16'h0001, 1'b0, 1'b1, "t6a");
        step(16'h0070, 1'b0, 1'b0, "t6b");
        check("t6_pending3", 32'(bus.pending_cnt), 3);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(bus.out_valid), 0);
        check("t6_rst_cnt", 32'(bus.pending_cnt), 0);
        check("t6_rst_ovr", 32'(bus.overrun), 0);
        #2;
        rst_n = 1'b1;
        model_reset();
        acc_log.delete();
        for (int i = 0; i < 4; i++) step(16'h0000, 1'b0, 1'b1, "t6idle");
        check("t6_no_codes", acc_log.size(), 0);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       ln = '0;
                1:       ln = N'(1) << $urandom_range(0, N-1);
                default: ln = N'($urandom) & N'($urandom) & N'($urandom);
            endcase
            step(ln, ($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0), "rnd");
        end
        for (int i = 0; i < 24; i++) step(16'h0000, 1'b0, 1'b1, "drain");
        check("drain_empty", 32'(bus.out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
